// File: rtl/wb_pkg.sv
// Shared definitions for the posted-write buffer: FSM encoding, entry width and
// transfer size codes.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DRAIN      = 2'd1,
    DRAIN_WAIT = 2'd2,
    READ_WAIT  = 2'd3
  } wb_state_e;

  localparam int ENTRY_W = 66;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Entry layout is {addr, size, wdata} so the address sits in the top bits.
  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [31:0] addr,
                                                    input logic [1:0]  size,
                                                    input logic [31:0] wdata);
    return {addr, size, wdata};
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding posted write entries; head is the oldest entry and
// pointers wrap naturally because DEPTH is a power of two.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [ENTRY_W-1:0] data_i,
  output logic [ENTRY_W-1:0] head_o,
  output logic [PTR_W:0]     count_o,
  output logic               full_o,
  output logic               empty_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q;
  logic [PTR_W-1:0]   tail_q;
  logic [PTR_W:0]     count_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) tail_q <= tail_q + 1'b1;
      if (pop_i)  head_q <= head_q + 1'b1;
      count_q <= count_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop_i);
    end
  end

  // Storage needs no reset; only the pointers define which slots are live.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[tail_q] <= data_i;
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/wb_write_buffer.sv
// Posted-write buffer between the cache's sram-like memory port and the AXI
// bridge; writes are acked after one cycle, reads bypass only when idle and empty.
module wb_write_buffer
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  output logic        mem_data_req,
  output logic        mem_data_wr,
  output logic [1:0]  mem_data_size,
  output logic [31:0] mem_data_addr,
  output logic [31:0] mem_data_wdata,
  input  logic [31:0] mem_data_rdata,
  input  logic        mem_data_addr_ok,
  input  logic        mem_data_data_ok,
  output logic        wb_empty
);

  wb_state_e          state_q, state_d;
  logic               ack_q;
  logic               push, pop;
  logic               fifo_full, fifo_empty;
  logic [PTR_W:0]     fifo_count, cnt_next;
  logic [ENTRY_W-1:0] head;

  assign push = resetn && cpu_data_req && cpu_data_wr && !fifo_full && (state_q != READ_WAIT);
  assign pop  = (state_q == DRAIN_WAIT) && mem_data_data_ok;
  assign cnt_next = fifo_count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

  wb_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pack_entry(cpu_data_addr, cpu_data_size, cpu_data_wdata)),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= push;
    end
  end

  always_comb begin
    state_d          = state_q;
    mem_data_req     = 1'b0;
    mem_data_wr      = 1'b0;
    mem_data_size    = 2'd0;
    mem_data_addr    = 32'd0;
    mem_data_wdata   = 32'd0;
    cpu_data_addr_ok = push;
    cpu_data_data_ok = ack_q;
    cpu_data_rdata   = 32'd0;
    wb_empty         = fifo_empty && (state_q == IDLE);

    unique case (state_q)
      IDLE: begin
        if (fifo_empty && cpu_data_req && !cpu_data_wr) begin
          mem_data_req     = 1'b1;
          mem_data_size    = cpu_data_size;
          mem_data_addr    = cpu_data_addr;
          cpu_data_addr_ok = mem_data_addr_ok;
          if (mem_data_addr_ok) state_d = READ_WAIT;
        end else if (push || !fifo_empty) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        mem_data_req   = 1'b1;
        mem_data_wr    = 1'b1;
        mem_data_addr  = head[65:34];
        mem_data_size  = head[33:32];
        mem_data_wdata = head[31:0];
        if (mem_data_addr_ok) state_d = DRAIN_WAIT;
      end
      DRAIN_WAIT: begin
        if (mem_data_data_ok) state_d = (cnt_next != '0) ? DRAIN : IDLE;
      end
      READ_WAIT: begin
        cpu_data_data_ok = mem_data_data_ok;
        cpu_data_rdata   = mem_data_rdata;
        if (mem_data_data_ok) state_d = IDLE;
      end
    endcase

    // Outputs are forced quiet while reset is held, including pass-through paths.
    if (!resetn) begin
      mem_data_req     = 1'b0;
      mem_data_wr      = 1'b0;
      mem_data_size    = 2'd0;
      mem_data_addr    = 32'd0;
      mem_data_wdata   = 32'd0;
      cpu_data_addr_ok = 1'b0;
      cpu_data_data_ok = 1'b0;
      cpu_data_rdata   = 32'd0;
      wb_empty         = 1'b0;
    end
  end

endmodule
